// File: rtl/flag_cond_resolver_pkg.sv
// -----------------------------------------------------------------------------
// flag_cond_resolver_pkg
// Constants shared by the branch resolver and the condition evaluator:
//   - 4-bit condition codes COND_AL..COND_LE
//   - bit positions of each flag inside the 8-bit flag word
//   - state encoding of the resolver FSM
// -----------------------------------------------------------------------------
package flag_cond_resolver_pkg;

   // Condition codes. Codes come in pairs: the odd code is the complement
   // of the even code just below it.
   localparam logic [3:0] COND_AL = 4'd0;
   localparam logic [3:0] COND_NV = 4'd1;
   localparam logic [3:0] COND_EQ = 4'd2;
   localparam logic [3:0] COND_NE = 4'd3;
   localparam logic [3:0] COND_CS = 4'd4;
   localparam logic [3:0] COND_CC = 4'd5;
   localparam logic [3:0] COND_MI = 4'd6;
   localparam logic [3:0] COND_PL = 4'd7;
   localparam logic [3:0] COND_VS = 4'd8;
   localparam logic [3:0] COND_VC = 4'd9;
   localparam logic [3:0] COND_HI = 4'd10;
   localparam logic [3:0] COND_LS = 4'd11;
   localparam logic [3:0] COND_GE = 4'd12;
   localparam logic [3:0] COND_LT = 4'd13;
   localparam logic [3:0] COND_GT = 4'd14;
   localparam logic [3:0] COND_LE = 4'd15;

   // Flag word bit map.
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_P = 4;
   localparam int FLAG_H = 5;
   localparam int FLAG_I = 6;
   localparam int FLAG_U = 7;

   // Resolver FSM states.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/flag_cond_resolver_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational condition-code evaluator.
// Ports:
//   flags [7:0] : flag word (C,Z,N,V,P,H,I,U from bit 0 upward)
//   cond  [3:0] : condition code
//   hit         : 1 when the condition holds for the given flags
// Only C, Z, N and V take part in any condition.
// -----------------------------------------------------------------------------
module cond_eval
   import flag_cond_resolver_pkg::*;
(
   input  logic [7:0] flags,
   input  logic [3:0] cond,
   output logic       hit
);

   logic c_f, z_f, n_f, v_f;
   logic unused_flags;

   assign c_f = flags[FLAG_C];
   assign z_f = flags[FLAG_Z];
   assign n_f = flags[FLAG_N];
   assign v_f = flags[FLAG_V];

   // P, H, I and U are carried in the word but never tested.
   assign unused_flags = ^flags[FLAG_U:FLAG_P];

   always_comb begin
      hit = 1'b0;
      case (cond)
         COND_AL: hit = 1'b1;
         COND_NV: hit = 1'b0;
         COND_EQ: hit = z_f;
         COND_NE: hit = ~z_f;
         COND_CS: hit = c_f;
         COND_CC: hit = ~c_f;
         COND_MI: hit = n_f;
         COND_PL: hit = ~n_f;
         COND_VS: hit = v_f;
         COND_VC: hit = ~v_f;
         COND_HI: hit = c_f & ~z_f;
         COND_LS: hit = ~c_f | z_f;
         COND_GE: hit = (n_f == v_f);
         COND_LT: hit = (n_f != v_f);
         COND_GT: hit = ~z_f & (n_f == v_f);
         COND_LE: hit = z_f | (n_f != v_f);
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_cond_resolver.sv
// -----------------------------------------------------------------------------
// flag_cond_resolver
// Consumer end of the flag register. Accepts a conditional-branch request,
// waits while a flag write is in flight, evaluates the condition on the
// settled flag word and drives the PC-load / pipeline-flush sequence.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE outside the Done
// cycle; request inputs are ignored whenever req_ready is low.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   flags, flag_busy  : flag word and "flag write in flight" (used in CHECK only)
//   req_valid/ready   : request handshake
//   req_cond/pc/target: condition code, branch address, branch target
//   done              : one-cycle pulse when a resolution completes
//   taken             : last resolution result, held until the next done
//   pc_load           : one-cycle pulse, load pc_next into the PC
//   pc_next           : resolved next PC
//   flush             : squash younger stages (FLUSH_CYCLES cycles when taken)
//   taken_count       : saturating count of taken branches
//   state_dbg         : current FSM state
// -----------------------------------------------------------------------------
module flag_cond_resolver
   import flag_cond_resolver_pkg::*;
#(
   parameter int PC_W         = 16,
   parameter int PC_INC       = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       flags,
   input  logic             flag_busy,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_cond,
   input  logic [PC_W-1:0]  req_pc,
   input  logic [PC_W-1:0]  req_target,
   output logic             done,
   output logic             taken,
   output logic             pc_load,
   output logic [PC_W-1:0]  pc_next,
   output logic             flush,
   output logic [CNT_W-1:0] taken_count,
   output logic [1:0]       state_dbg
);

   // The PCLoad cycle is the first flush cycle, so the counter is loaded
   // with the number of flush cycles still remaining after it.
   localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [PC_W-1:0] PC_STEP    = PC_W'(PC_INC);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       state_q;
   logic [3:0]       cond_q;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  target_q;
   logic [3:0]       flush_cnt_q;
   logic             done_q;
   logic             taken_q;
   logic             pc_load_q;
   logic [PC_W-1:0]  pc_next_q;
   logic             flush_q;
   logic [CNT_W-1:0] taken_count_q;
   logic             hit;

   cond_eval u_cond_eval (
      .flags (flags),
      .cond  (cond_q),
      .hit   (hit)
   );

   // On the not-taken path the FSM is already back in IDLE during the Done
   // cycle; holding ready low there gives the first accept one cycle later.
   assign req_ready = (state_q == ST_IDLE) && !done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cond_q        <= 4'd0;
         pc_q          <= '0;
         target_q      <= '0;
         flush_cnt_q   <= 4'd0;
         done_q        <= 1'b0;
         taken_q       <= 1'b0;
         pc_load_q     <= 1'b0;
         pc_next_q     <= '0;
         flush_q       <= 1'b0;
         taken_count_q <= '0;
      end else begin
         done_q    <= 1'b0;
         pc_load_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  cond_q   <= req_cond;
                  pc_q     <= req_pc;
                  target_q <= req_target;
                  state_q  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!flag_busy) begin
                  done_q  <= 1'b1;
                  taken_q <= hit;
                  if (hit) begin
                     pc_next_q   <= target_q;
                     pc_load_q   <= 1'b1;
                     flush_q     <= 1'b1;
                     flush_cnt_q <= FLUSH_LOAD;
                     state_q     <= ST_FLUSH;
                     if (taken_count_q != {CNT_W{1'b1}}) begin
                        taken_count_q <= taken_count_q + CNT_ONE;
                     end
                  end else begin
                     pc_next_q <= pc_q + PC_STEP;
                     state_q   <= ST_IDLE;
                  end
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_q == 4'd0) begin
                  flush_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign done        = done_q;
   assign taken       = taken_q;
   assign pc_load     = pc_load_q;
   assign pc_next     = pc_next_q;
   assign flush       = flush_q;
   assign taken_count = taken_count_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_flag_cond_resolver.sv
// -----------------------------------------------------------------------------
// tb_flag_cond_resolver
// Drives branch requests into two resolvers sharing the same inputs: the
// default configuration and one with a 2-bit taken counter, so counter
// saturation is reached quickly. Expected results come from a flag-pair
// reference model and a queue of expected next-PC values.
// -----------------------------------------------------------------------------
module tb_flag_cond_resolver;
   import flag_cond_resolver_pkg::*;

   localparam int PC_W         = 16;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 16;
   localparam int SAT_W        = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       flags = 8'h00;
   logic             flag_busy = 1'b0;
   logic             req_valid = 1'b0;
   logic [3:0]       req_cond = 4'd0;
   logic [PC_W-1:0]  req_pc = '0;
   logic [PC_W-1:0]  req_target = '0;

   logic             req_ready, done, taken, pc_load, flush;
   logic [PC_W-1:0]  pc_next;
   logic [CNT_W-1:0] taken_count;
   logic [1:0]       state_dbg;

   logic             sat_ready, sat_done, sat_taken, sat_pc_load, sat_flush;
   logic [PC_W-1:0]  sat_pc_next;
   logic [SAT_W-1:0] sat_count;
   logic [1:0]       sat_state;

   int total = 0;
   int bad   = 0;
   int model_cnt = 0;
   logic [PC_W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   flag_cond_resolver #(
      .PC_W(PC_W), .PC_INC(1), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flags(flags), .flag_busy(flag_busy),
      .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
      .req_pc(req_pc), .req_target(req_target), .done(done), .taken(taken),
      .pc_load(pc_load), .pc_next(pc_next), .flush(flush),
      .taken_count(taken_count), .state_dbg(state_dbg)
   );

   flag_cond_resolver #(
      .PC_W(PC_W), .PC_INC(1), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(SAT_W)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .flags(flags), .flag_busy(flag_busy),
      .req_valid(req_valid), .req_ready(sat_ready), .req_cond(req_cond),
      .req_pc(req_pc), .req_target(req_target), .done(sat_done), .taken(sat_taken),
      .pc_load(sat_pc_load), .pc_next(sat_pc_next), .flush(sat_flush),
      .taken_count(sat_count), .state_dbg(sat_state)
   );

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: codes pair up as (predicate, complement); bit 0 inverts.
   function automatic logic ref_hit(input logic [3:0] c, input logic [7:0] f);
      logic cf, zf, nf, vf, base;
      cf = f[0]; zf = f[1]; nf = f[2]; vf = f[3];
      case (c[3:1])
         3'd0: base = 1'b1;
         3'd1: base = zf;
         3'd2: base = cf;
         3'd3: base = nf;
         3'd4: base = vf;
         3'd5: base = cf && !zf;
         3'd6: base = (nf == vf);
         default: base = !zf && (nf == vf);
      endcase
      return base ^ c[0];
   endfunction

   task automatic check_counts(input string tag);
      int exp_main, exp_sat;
      exp_main = (model_cnt > 65535) ? 65535 : model_cnt;
      exp_sat  = (model_cnt > 3) ? 3 : model_cnt;
      check_eq({tag, "_count"}, 32'(taken_count), 32'(exp_main));
      check_eq({tag, "_satcount"}, 32'(sat_count), 32'(exp_sat));
   endtask

   // ---------------- driver ----------------
   // Called just after a negedge with the resolver idle. Checks the exact
   // cycle-by-cycle timing of one resolution. abort=1 pulls reset during
   // the PCLoad cycle of a taken branch.
   task automatic do_branch(input logic [3:0] c, input logic [7:0] f,
                            input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                            input int busy, input bit abort);
      logic hit;
      int   nxt;
      hit = ref_hit(c, f);
      nxt = int'(pc) + 1;
      if (nxt > 65535) nxt = 0;
      exp_q.push_back(hit ? tgt : PC_W'(nxt));

      check_eq("ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_cond   = c;
      req_pc     = pc;
      req_target = tgt;
      flags      = 8'($urandom);
      flag_busy  = 1'($urandom);
      @(negedge clk);
      // CHECK cycle; request inputs now ignored
      check_eq("ready_check", 32'(req_ready), 32'd0);
      check_eq("done_check", 32'(done), 32'd0);
      check_eq("state_check", 32'(state_dbg), 32'(ST_CHECK));
      req_valid  = 1'($urandom);
      req_cond   = 4'($urandom);
      req_pc     = PC_W'($urandom);
      req_target = PC_W'($urandom);
      for (int i = 0; i < busy; i++) begin
         flag_busy = 1'b1;
         flags     = f ^ 8'h0F;
         @(negedge clk);
         check_eq("done_stall", 32'(done), 32'd0);
         check_eq("ready_stall", 32'(req_ready), 32'd0);
      end
      flag_busy = 1'b0;
      flags     = f;
      @(negedge clk);
      // Done cycle
      flags     = 8'($urandom);
      flag_busy = 1'($urandom);
      if (hit) model_cnt++;
      check_eq("done", 32'(done), 32'd1);
      check_eq("taken", 32'(taken), 32'(hit));
      check_eq("pc_load", 32'(pc_load), 32'(hit));
      check_eq("flush_first", 32'(flush), 32'(hit));
      check_eq("pc_next", 32'(pc_next), 32'(exp_q.pop_front()));
      check_eq("ready_done", 32'(req_ready), 32'd0);
      check_counts("done");
      if (hit && abort) begin
         #2 rst_n = 1'b0;
         #1;
         model_cnt = 0;
         check_eq("rst_flush", 32'(flush), 32'd0);
         check_eq("rst_pc_load", 32'(pc_load), 32'd0);
         check_eq("rst_done", 32'(done), 32'd0);
         check_eq("rst_pc_next", 32'(pc_next), 32'd0);
         check_counts("rst");
         req_valid = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check_eq("rst_ready", 32'(req_ready), 32'd1);
         check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
         return;
      end
      if (hit) begin
         for (int i = 1; i < FLUSH_CYCLES; i++) begin
            @(negedge clk);
            check_eq("flush_hold", 32'(flush), 32'd1);
            check_eq("pc_load_pulse", 32'(pc_load), 32'd0);
            check_eq("done_pulse", 32'(done), 32'd0);
            check_eq("ready_flush", 32'(req_ready), 32'd0);
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("ready_back", 32'(req_ready), 32'd1);
      check_eq("flush_end", 32'(flush), 32'd0);
      check_eq("done_end", 32'(done), 32'd0);
      check_eq("taken_held", 32'(taken), 32'(hit));
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] sweep_flags [7] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0A, 8'h05};

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_eq("reset_ready", 32'(req_ready), 32'd1);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_taken", 32'(taken), 32'd0);
      check_eq("reset_pc_load", 32'(pc_load), 32'd0);
      check_eq("reset_flush", 32'(flush), 32'd0);
      check_eq("reset_pc_next", 32'(pc_next), 32'd0);
      check_eq("reset_state", 32'(state_dbg), 32'(ST_IDLE));
      check_counts("reset");

      // Taken EQ, not-taken EQ with PC wrap, stalled VS.
      do_branch(COND_EQ, 8'h02, 16'h0010, 16'h0200, 0, 1'b0);
      do_branch(COND_EQ, 8'h00, 16'hFFFF, 16'h0200, 0, 1'b0);
      do_branch(COND_VS, 8'h08, 16'h0100, 16'h0300, 3, 1'b0);

      // All codes over a fixed set of flag words.
      for (int c = 0; c < 16; c++) begin
         for (int k = 0; k < 7; k++) begin
            do_branch(4'(c), sweep_flags[k], PC_W'($urandom), PC_W'($urandom), 0, 1'b0);
         end
      end

      // Reset during FLUSH, then a normal resolution.
      do_branch(COND_AL, 8'($urandom), 16'h0040, 16'h0800, 0, 1'b1);
      do_branch(COND_NE, 8'h00, 16'h0041, 16'h0900, 0, 1'b0);

      // Enough taken branches to saturate the 2-bit counter and hold it.
      for (int i = 0; i < 5; i++) begin
         do_branch(COND_AL, 8'($urandom), PC_W'($urandom), PC_W'($urandom), 0, 1'b0);
      end

      // Random mix with random stall lengths.
      for (int i = 0; i < 150; i++) begin
         do_branch(4'($urandom), 8'($urandom), PC_W'($urandom), PC_W'($urandom),
                   $urandom_range(0, 3), 1'b0);
      end

      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
